sdrc_wb_bist: RTL and testbench
===============================

# sdrc_wb_bist

Synthesisable Wishbone master that exercises the SDRAM controller's application port with a parametrised write-then-read-verify pass. It replaces the behavioural test driver for bring-up: it sits on `sys_clk` directly in front of `sdrc_top`'s Wishbone slave port, waits for `sdr_init_done`, and issues incrementing bursts of configurable length and data pattern. It then reads the region back, compares it, and reports a pass/fail status with an error count and the first failing address.

## Interface
- `APP_AW`, 26: Wishbone byte-address width.
- `WB_DW`, 32: data width; 8, 16 or 32. `SEL_W = WB_DW/8`.
- `MAX_BURST`, 8: maximum beats per burst. Power of two, 1..16.
- `TIMEOUT`, 1024: `sys_clk` cycles allowed per beat without `wb_ack_i` before abort.

Ports:
- `sys_clk` in 1: single clock for the whole block.
- `resetn` in 1: reset; asynchronous assert, active low.
- `start` in 1: single-cycle pulse that begins a run; ignored while `busy`.
- `cfg_mode` in 2: data pattern. 0 = increment, 1 = walking-one, 2 = LFSR, 3 = address-as-data.
- `cfg_base_addr` in `APP_AW`: start byte address, `SEL_W`-aligned.
- `cfg_num_words` in 16: number of words to write and then read.
- `cfg_burst_len` in 5: beats per burst, 1..`MAX_BURST`. Values of 0 or above `MAX_BURST` clamp to `MAX_BURST`.
- `sdr_init_done` in 1: controller initialisation complete.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each: Wishbone master controls.
- `wb_addr_o` out `APP_AW`: Wishbone address.
- `wb_dat_o` out `WB_DW`: write data.
- `wb_sel_o` out `SEL_W`: byte selects.
- `wb_cti_o` out 3: cycle type identifier.
- `wb_ack_i` in 1: Wishbone acknowledge.
- `wb_dat_i` in `WB_DW`: read data.
- `busy`, `done`, `pass`, `timeout` out 1 each: run status.
- `err_count` out 16: number of miscompares.
- `first_err_addr` out `APP_AW`: address of the first miscompare.

## Operation
- Reset value of every output is 0. FSM resets to IDLE.
- At `start`, all `cfg_*` inputs are latched. `done`, `pass`, `timeout`, `err_count` and `first_err_addr` clear. `busy` goes to 1.
- FSM states and transitions:
  - IDLE → WAIT_INIT on `start`.
  - WAIT_INIT → WR_BURST once `sdr_init_done` = 1.
  - WR_BURST → WR_GAP at the end of each burst.
  - WR_GAP → WR_BURST while write words remain.
  - WR_GAP → RD_BURST once all words are written; address and pattern generator reload here.
  - RD_BURST → RD_GAP at the end of each burst.
  - RD_GAP → RD_BURST while read words remain.
  - RD_GAP → FINISH once all words are read.
  - FINISH → IDLE.
- `cfg_num_words` = 0 takes IDLE → FINISH directly: `done` = 1, `pass` = 1, no bus activity.
- Burst length is min(latched burst length, remaining words). The final burst is truncated accordingly.
- During a burst:
  - `wb_cyc_o` = `wb_stb_o` = 1 and `wb_sel_o` = all ones.
  - `wb_cti_o` = 3'b010 on every beat except the last, which carries 3'b111. A single-beat burst uses 3'b111.
  - A beat completes on a cycle with `wb_ack_i` = 1. On completion, address advances by `SEL_W` and the pattern advances.
- Address wraps modulo 2^`APP_AW`.
- Patterns for word index i:
  - Increment: i zero-extended to `WB_DW`.
  - Walking-one: 1 << (i mod `WB_DW`).
  - LFSR: Galois, taps from the package per `WB_DW`, seed all-ones. The same sequence regenerates for the read pass.
  - Address-as-data: byte address, truncated or zero-extended to `WB_DW`.
- Compare happens on each read ack. On a mismatch:
  - `err_count` increments, saturating at 16'hFFFF.
  - On the first mismatch only, `first_err_addr` captures the beat address.
- Watchdog: counts cycles with `wb_stb_o` = 1 and `wb_ack_i` = 0, and resets on each ack. On reaching `TIMEOUT`:
  - Drop `wb_cyc_o` and `wb_stb_o`.
  - Set `timeout` = 1 and go to FINISH.
  - `pass` = 0.
- In FINISH: `busy` → 0; `done` → 1; `pass` = (`err_count` == 0) && !`timeout`. All status outputs hold until the next accepted `start`.
- `resetn` asserted mid-run: all outputs go to 0 immediately. This includes `wb_cyc_o`, which terminates the bus cycle. No partial status is retained.

## Timing
- `wb_*` outputs are registered. `wb_cyc_o` rises the cycle after entering a BURST state.
- Beat throughput is one per cycle while `wb_ack_i` is held high. Address, data and `cti` update in the same cycle the ack is sampled.
- The GAP state holds `wb_cyc_o` = 0 for exactly 1 cycle between bursts. This lets the controller's request FIFO arbitrate.
- The read data compare is registered. `err_count` and `first_err_addr` update 1 cycle after the ack.
- `done` rises 2 cycles after the final read ack: 1 cycle for the compare, 1 cycle in FINISH.
- `start` arriving in the same cycle as a timeout is ignored.

## Structure
- Shared package `sdrc_bist_pkg` holds:
  - the FSM state enum;
  - the `cfg_mode` encodings;
  - the CTI constants (3'b010, 3'b111);
  - the LFSR tap constants for widths 8, 16 and 32.
- One sub-module, `sdrc_bist_patgen`, generates the pattern. Inputs: mode, base address, `load`, `advance`. Output: current word. Two instances are used, one for write data and one for expected read data, so the compare never depends on stored write data.

## Test plan
- Mode 0, base 0x0, 16 words, burst 4 → 4 write bursts and 4 read bursts, each with `cti` sequence 010,010,010,111. Result: `done` = 1, `pass` = 1, `err_count` = 0.
- Mode 2, 10 words, burst 8 → bursts of 8 and 2 beats on both passes; the 2-beat burst's final `cti` = 111. Result: `pass` = 1.
- Read-data corruption model flips bit 0 at byte address 0x20 (mode 3, base 0x0, 32 words) → `err_count` = 1, `first_err_addr` = 0x20, `pass` = 0.
- Ack never asserted, `TIMEOUT` = 16 → `wb_cyc_o` drops 16 cycles after `stb` rises; `timeout` = 1, `done` = 1, `pass` = 0.
- `cfg_num_words` = 0 → `done` = 1 and `pass` = 1 two cycles after `start`, with no `wb_cyc_o`. Separately: `sdr_init_done` low delays the first `cyc` until it rises.
- `resetn` pulsed low mid-write-burst → all outputs 0 within the reset pulse. A following `start` re-runs cleanly with `pass` = 1.

Source files
------------

// File: rtl/sdrc_bist_pkg.sv
// Shared types and constants for the SDRAM Wishbone BIST master and its pattern generator.
package sdrc_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_WR_BURST,
    S_WR_GAP,
    S_RD_BURST,
    S_RD_GAP,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_WALK = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_ADDR = 2'd3
  } mode_t;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  // Right-shifting Galois LFSR masks (tap at bit n-1 for x^n).
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return 32'(LFSR_TAPS_8);
      16:      return 32'(LFSR_TAPS_16);
      default: return LFSR_TAPS_32;
    endcase
  endfunction

endpackage

// File: rtl/sdrc_bist_patgen.sv
// Data pattern generator: reloads to word 0 on load, steps one word per advance.
module sdrc_bist_patgen
  import sdrc_bist_pkg::*;
#(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned WB_DW  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  mode_t             mode,
  input  logic [APP_AW-1:0] base_addr,
  input  logic              load,
  input  logic              advance,
  output logic [WB_DW-1:0]  word
);

  localparam int unsigned SEL_W = WB_DW / 8;
  localparam logic [WB_DW-1:0] TAPS = WB_DW'(lfsr_taps(WB_DW));

  logic [APP_AW-1:0] addr;
  logic [APP_AW-1:0] addr_next_c;
  logic [WB_DW-1:0]  word_next_c;
  logic [WB_DW-1:0]  word_init_c;

  assign addr_next_c = addr + APP_AW'(SEL_W);

  // First word of the sequence and the step from the current word.
  always_comb begin
    word_init_c = '0;
    word_next_c = word;
    case (mode)
      MODE_INC: begin
        word_init_c = '0;
        word_next_c = word + WB_DW'(1);
      end
      MODE_WALK: begin
        word_init_c = WB_DW'(1);
        word_next_c = {word[WB_DW-2:0], word[WB_DW-1]};
      end
      MODE_LFSR: begin
        word_init_c = '1;
        word_next_c = word[0] ? ((word >> 1) ^ TAPS) : (word >> 1);
      end
      MODE_ADDR: begin
        word_init_c = WB_DW'(base_addr);
        word_next_c = WB_DW'(addr_next_c);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      word <= '0;
    end else if (load) begin
      addr <= base_addr;
      word <= word_init_c;
    end else if (advance) begin
      addr <= addr_next_c;
      word <= word_next_c;
    end
  end

endmodule

// File: rtl/sdrc_wb_bist.sv
// Wishbone BIST master: writes a pattern region in bursts, reads it back and reports miscompares.
module sdrc_wb_bist
  import sdrc_bist_pkg::*;
#(
  parameter int unsigned APP_AW    = 26,
  parameter int unsigned WB_DW     = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                  sys_clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [APP_AW-1:0]     cfg_base_addr,
  input  logic [15:0]           cfg_num_words,
  input  logic [4:0]            cfg_burst_len,
  input  logic                  sdr_init_done,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [APP_AW-1:0]     wb_addr_o,
  output logic [WB_DW-1:0]      wb_dat_o,
  output logic [WB_DW/8-1:0]    wb_sel_o,
  output logic [2:0]            wb_cti_o,
  input  logic                  wb_ack_i,
  input  logic [WB_DW-1:0]      wb_dat_i,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [APP_AW-1:0]     first_err_addr
);

  localparam int unsigned SEL_W = WB_DW / 8;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  mode_t             mode_q;
  logic [APP_AW-1:0] base_q;
  logic [15:0]       num_q;
  logic [4:0]        blen_q;
  logic [15:0]       words_left;
  logic [4:0]        beats_left;
  logic [WD_W-1:0]   wd_cnt;

  logic              cmp_valid;
  logic [WB_DW-1:0]  cmp_data;
  logic [WB_DW-1:0]  cmp_exp;
  logic [APP_AW-1:0] cmp_addr;

  logic [WB_DW-1:0]  wr_word;
  logic [WB_DW-1:0]  rd_word;

  logic              beat_ack_c;
  logic              wd_expire_c;
  logic              wr_load_c;
  logic              rd_load_c;
  logic              burst_entry_c;
  logic [15:0]       rem_c;
  logic [4:0]        beats_c;

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n     = state;
    beat_ack_c  = wb_cyc_o && wb_stb_o && wb_ack_i;
    wd_expire_c = wb_stb_o && !wb_ack_i && (wd_cnt == WD_W'(TIMEOUT - 1));
    wr_load_c   = 1'b0;
    rd_load_c   = 1'b0;
    rem_c       = words_left;
    case (state)
      S_IDLE:
        if (start) state_n = (cfg_num_words == 16'd0) ? S_FINISH : S_WAIT_INIT;
      S_WAIT_INIT:
        if (sdr_init_done) begin
          state_n   = S_WR_BURST;
          wr_load_c = 1'b1;
        end
      S_WR_BURST:
        if (wd_expire_c)                              state_n = S_FINISH;
        else if (beat_ack_c && beats_left == 5'd1)   state_n = S_WR_GAP;
      S_WR_GAP:
        if (words_left == 16'd0) begin
          state_n   = S_RD_BURST;
          rd_load_c = 1'b1;
          rem_c     = num_q;
        end else begin
          state_n = S_WR_BURST;
        end
      S_RD_BURST:
        if (wd_expire_c)                              state_n = S_FINISH;
        else if (beat_ack_c && beats_left == 5'd1)   state_n = S_RD_GAP;
      S_RD_GAP:
        state_n = (words_left == 16'd0) ? S_FINISH : S_RD_BURST;
      S_FINISH:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
    burst_entry_c = ((state_n == S_WR_BURST) && (state != S_WR_BURST)) ||
                    ((state_n == S_RD_BURST) && (state != S_RD_BURST));
    beats_c = (rem_c < 16'(blen_q)) ? 5'(rem_c) : blen_q;
  end

  // Bus sequencing, watchdog, compare pipeline and run status.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_addr_o      <= '0;
      wb_sel_o       <= '0;
      wb_cti_o       <= 3'b000;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= 16'd0;
      first_err_addr <= '0;
      mode_q         <= MODE_INC;
      base_q         <= '0;
      num_q          <= 16'd0;
      blen_q         <= 5'd0;
      words_left     <= 16'd0;
      beats_left     <= 5'd0;
      wd_cnt         <= '0;
      cmp_valid      <= 1'b0;
      cmp_data       <= '0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        mode_q         <= mode_t'(cfg_mode);
        base_q         <= cfg_base_addr;
        num_q          <= cfg_num_words;
        words_left     <= cfg_num_words;
        blen_q         <= (cfg_burst_len == 5'd0 || cfg_burst_len > 5'(MAX_BURST)) ?
                          5'(MAX_BURST) : cfg_burst_len;
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
        err_count      <= 16'd0;
        first_err_addr <= '0;
      end

      if (burst_entry_c) begin
        wb_cyc_o   <= 1'b1;
        wb_stb_o   <= 1'b1;
        wb_we_o    <= (state_n == S_WR_BURST);
        wb_sel_o   <= '1;
        wb_cti_o   <= (beats_c == 5'd1) ? CTI_EOB : CTI_INCR;
        beats_left <= beats_c;
        wd_cnt     <= '0;
        if (wr_load_c || rd_load_c) wb_addr_o <= base_q;
        if (rd_load_c)              words_left <= num_q;
      end else if (beat_ack_c) begin
        wb_addr_o  <= wb_addr_o + APP_AW'(SEL_W);
        words_left <= words_left - 16'd1;
        beats_left <= beats_left - 5'd1;
        wd_cnt     <= '0;
        if (beats_left == 5'd1) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_sel_o <= '0;
          wb_cti_o <= 3'b000;
        end else begin
          wb_cti_o <= (beats_left == 5'd2) ? CTI_EOB : CTI_INCR;
        end
      end else if (wd_expire_c) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_sel_o <= '0;
        wb_cti_o <= 3'b000;
        timeout  <= 1'b1;
      end else if (wb_stb_o) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end

      // Read beats are compared one cycle after their ack.
      cmp_valid <= beat_ack_c && !wb_we_o;
      if (beat_ack_c && !wb_we_o) begin
        cmp_data <= wb_dat_i;
        cmp_exp  <= rd_word;
        cmp_addr <= wb_addr_o;
      end
      if (cmp_valid && (cmp_data != cmp_exp)) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0)    first_err_addr <= cmp_addr;
      end

      if (state == S_FINISH) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == 16'd0) && !timeout;
      end
    end
  end

  sdrc_bist_patgen #(.APP_AW(APP_AW), .WB_DW(WB_DW)) u_wr_gen (
    .clk       (sys_clk),
    .rst_n     (resetn),
    .mode      (mode_q),
    .base_addr (base_q),
    .load      (wr_load_c),
    .advance   (beat_ack_c && wb_we_o),
    .word      (wr_word)
  );

  // Independent generator so expected read data never depends on stored write data.
  sdrc_bist_patgen #(.APP_AW(APP_AW), .WB_DW(WB_DW)) u_rd_gen (
    .clk       (sys_clk),
    .rst_n     (resetn),
    .mode      (mode_q),
    .base_addr (base_q),
    .load      (rd_load_c),
    .advance   (beat_ack_c && !wb_we_o),
    .word      (rd_word)
  );

  assign wb_dat_o = wr_word;

endmodule

// File: tb/tb_sdrc_wb_bist.sv
// Directed bench for sdrc_wb_bist with a memory-backed Wishbone slave and fault injection.
module tb_sdrc_wb_bist;

  logic        sys_clk;
  logic        resetn;
  logic        start;
  logic [1:0]  cfg_mode;
  logic [25:0] cfg_base_addr;
  logic [15:0] cfg_num_words;
  logic [4:0]  cfg_burst_len;
  logic        sdr_init_done;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [25:0] first_err_addr;

  int checks = 0;
  int errors = 0;

  logic        ack_en;
  logic        corrupt_en;
  logic [25:0] corrupt_addr;
  logic [31:0] mem [256];

  logic [2:0]  q_cti[$];
  logic [3:0]  q_sel[$];
  logic        q_we[$];
  logic [25:0] q_addr[$];
  logic [31:0] q_dat[$];
  int          bursts = 0;
  int          stb_cycles = 0;
  int          cyc_cnt = 0;
  int          last_rd_edge = 0;
  int          done_edge = 0;
  logic        cyc_prev = 1'b0;
  logic        done_prev = 1'b0;

  sdrc_wb_bist #(.APP_AW(26), .WB_DW(32), .MAX_BURST(8), .TIMEOUT(16)) dut (
    .sys_clk        (sys_clk),
    .resetn         (resetn),
    .start          (start),
    .cfg_mode       (cfg_mode),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_words  (cfg_num_words),
    .cfg_burst_len  (cfg_burst_len),
    .sdr_init_done  (sdr_init_done),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_addr_o      (wb_addr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel_o),
    .wb_cti_o       (wb_cti_o),
    .wb_ack_i       (wb_ack_i),
    .wb_dat_i       (wb_dat_i),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
  assign wb_dat_i = mem[wb_addr_o[9:2]] ^ {31'b0, corrupt_en && (wb_addr_o == corrupt_addr)};

  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  // Bus monitor and memory model; a beat seen here completes at the next rising edge.
  always @(negedge sys_clk) begin
    if (wb_cyc_o && wb_stb_o) stb_cycles <= stb_cycles + 1;
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      q_cti.push_back(wb_cti_o);
      q_sel.push_back(wb_sel_o);
      q_we.push_back(wb_we_o);
      q_addr.push_back(wb_addr_o);
      q_dat.push_back(wb_dat_o);
      if (wb_we_o) mem[wb_addr_o[9:2]] <= wb_dat_o;
      else         last_rd_edge <= cyc_cnt + 1;
    end
    if (wb_cyc_o && !cyc_prev) bursts <= bursts + 1;
    cyc_prev <= wb_cyc_o;
    if (done && !done_prev) done_edge <= cyc_cnt;
    done_prev <= done;
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  task automatic run(input logic [1:0] m, input logic [25:0] b, input logic [15:0] n,
                     input logic [4:0] bl, output bit ok);
    cfg_mode      = m;
    cfg_base_addr = b;
    cfg_num_words = n;
    cfg_burst_len = bl;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin errors++;
      $display("FAIL reset_bus_ctl cyc=%b stb=%b we=%b want 000", wb_cyc_o, wb_stb_o, wb_we_o); end
    checks++; if (wb_addr_o !== 26'd0 || wb_sel_o !== 4'd0 || wb_cti_o !== 3'd0 || wb_dat_o !== 32'd0) begin errors++;
      $display("FAIL reset_bus_data addr=%h sel=%h cti=%b dat=%h want 0", wb_addr_o, wb_sel_o, wb_cti_o, wb_dat_o); end
    checks++; if ({busy, done, pass, timeout} !== 4'b0000) begin errors++;
      $display("FAIL reset_status got %b want 0000", {busy, done, pass, timeout}); end
    checks++; if (err_count !== 16'd0 || first_err_addr !== 26'd0) begin errors++;
      $display("FAIL reset_err got cnt=%0d addr=%h want 0", err_count, first_err_addr); end
  endtask

  task automatic test_increment();
    bit ok; int b0, n0, nb, bad;
    logic [2:0] ecti;
    b0 = q_cti.size(); n0 = bursts;
    run(2'd0, 26'h0, 16'd16, 5'd4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL inc_done_wait got timeout want done"); end
    nb = q_cti.size() - b0;
    checks++; if (nb != 32 || bursts - n0 != 8) begin errors++;
      $display("FAIL inc_counts beats=%0d bursts=%0d want 32 8", nb, bursts - n0); end
    bad = 0;
    for (int k = 0; k < nb; k++) begin
      ecti = (k % 4 == 3) ? 3'b111 : 3'b010;
      if (q_cti[b0+k] !== ecti || q_sel[b0+k] !== 4'hF) bad++;
      if (k < 16 && (q_we[b0+k] !== 1'b1 || q_addr[b0+k] !== 26'(4*k) || q_dat[b0+k] !== 32'(k))) bad++;
      if (k >= 16 && (q_we[b0+k] !== 1'b0 || q_addr[b0+k] !== 26'(4*(k-16)))) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL inc_beats bad=%0d want 0", bad); end
    checks++; if (done_edge - last_rd_edge != 2) begin errors++;
      $display("FAIL inc_done_latency got %0d want 2", done_edge - last_rd_edge); end
    checks++; if ({done, pass, busy, timeout} !== 4'b1100 || err_count !== 16'd0) begin errors++;
      $display("FAIL inc_status dpbt=%b err=%0d want 1100 0", {done, pass, busy, timeout}, err_count); end
  endtask

  task automatic test_walk();
    bit ok; int b0, n0, nb, bad, p;
    logic [2:0] ecti;
    b0 = q_cti.size(); n0 = bursts;
    run(2'd1, 26'h40, 16'd5, 5'd2, ok);
    nb = q_cti.size() - b0;
    checks++; if (!ok || nb != 10 || bursts - n0 != 6) begin errors++;
      $display("FAIL walk_counts ok=%0d beats=%0d bursts=%0d want 1 10 6", ok, nb, bursts - n0); end
    bad = 0;
    for (int k = 0; k < nb; k++) begin
      p = k % 5;
      ecti = (p == 1 || p == 3 || p == 4) ? 3'b111 : 3'b010;
      if (q_cti[b0+k] !== ecti || q_addr[b0+k] !== 26'(32'h40 + 4*p)) bad++;
      if (k < 5 && q_dat[b0+k] !== (32'd1 << p)) bad++;
    end
    checks++; if (bad != 0 || pass !== 1'b1) begin errors++;
      $display("FAIL walk_beats bad=%0d pass=%b want 0 1", bad, pass); end
  endtask

  task automatic test_lfsr();
    bit ok; int b0, n0, nb, bad, p;
    logic [2:0] ecti;
    logic [31:0] x;
    b0 = q_cti.size(); n0 = bursts;
    run(2'd2, 26'h100, 16'd10, 5'd8, ok);
    nb = q_cti.size() - b0;
    checks++; if (!ok || nb != 20 || bursts - n0 != 4) begin errors++;
      $display("FAIL lfsr_counts ok=%0d beats=%0d bursts=%0d want 1 20 4", ok, nb, bursts - n0); end
    bad = 0;
    x = 32'hFFFF_FFFF;
    for (int k = 0; k < nb; k++) begin
      p = k % 10;
      ecti = (p == 7 || p == 9) ? 3'b111 : 3'b010;
      if (q_cti[b0+k] !== ecti) bad++;
      if (k < 10) begin
        if (q_dat[b0+k] !== x) bad++;
        x = lfsr_next(x);
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lfsr_beats bad=%0d want 0", bad); end
    checks++; if (pass !== 1'b1 || err_count !== 16'd0) begin errors++;
      $display("FAIL lfsr_status pass=%b err=%0d want 1 0", pass, err_count); end
  endtask

  task automatic test_corrupt();
    bit ok; int b0, n0, bad;
    b0 = q_cti.size(); n0 = bursts;
    corrupt_addr = 26'h20;
    corrupt_en   = 1'b1;
    run(2'd3, 26'h0, 16'd32, 5'd0, ok);
    corrupt_en = 1'b0;
    checks++; if (!ok || bursts - n0 != 8) begin errors++;
      $display("FAIL corrupt_bursts ok=%0d bursts=%0d want 1 8", ok, bursts - n0); end
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (q_dat[b0+k] !== 32'(4*k)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL corrupt_wdata bad=%0d want 0", bad); end
    checks++; if (err_count !== 16'd1 || first_err_addr !== 26'h20) begin errors++;
      $display("FAIL corrupt_err got cnt=%0d addr=%h want 1 20", err_count, first_err_addr); end
    checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++;
      $display("FAIL corrupt_status pass=%b done=%b want 0 1", pass, done); end
  endtask

  task automatic test_timeout();
    bit ok; int s0;
    ack_en = 1'b0;
    s0 = stb_cycles;
    run(2'd0, 26'h0, 16'd4, 5'd4, ok);
    ack_en = 1'b1;
    checks++; if (!ok || stb_cycles - s0 != 16) begin errors++;
      $display("FAIL timeout_stb ok=%0d stb_cycles=%0d want 1 16", ok, stb_cycles - s0); end
    checks++; if ({timeout, done, pass, busy, wb_cyc_o} !== 5'b11000) begin errors++;
      $display("FAIL timeout_status tdpbc=%b want 11000", {timeout, done, pass, busy, wb_cyc_o}); end
  endtask

  task automatic test_zero_words();
    int n0;
    n0 = bursts;
    cfg_num_words = 16'd0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_early got done=%b want 0", done); end
    @(negedge sys_clk);
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++;
      $display("FAIL zero_done got done=%b pass=%b want 1 1", done, pass); end
    @(negedge sys_clk);
    checks++; if (bursts != n0) begin errors++; $display("FAIL zero_bus got bursts=%0d want 0", bursts - n0); end
  endtask

  task automatic test_init_wait();
    bit ok; int n0;
    n0 = bursts;
    sdr_init_done = 1'b0;
    cfg_mode = 2'd0; cfg_base_addr = 26'h0; cfg_num_words = 16'd4; cfg_burst_len = 5'd4;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (20) @(negedge sys_clk);
    checks++; if (bursts != n0 || busy !== 1'b1) begin errors++;
      $display("FAIL init_hold got bursts=%0d busy=%b want 0 1", bursts - n0, busy); end
    sdr_init_done = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    @(negedge sys_clk);
    checks++; if (!ok || pass !== 1'b1 || bursts - n0 != 2) begin errors++;
      $display("FAIL init_run ok=%0d pass=%b bursts=%0d want 1 1 2", ok, pass, bursts - n0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    cfg_mode = 2'd0; cfg_base_addr = 26'h0; cfg_num_words = 16'd16; cfg_burst_len = 5'd4;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !wb_cyc_o; i++) @(negedge sys_clk);
    checks++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1) begin errors++;
      $display("FAIL rstmid_active got cyc=%b we=%b want 1 1", wb_cyc_o, wb_we_o); end
    @(negedge sys_clk);
    resetn = 1'b0;
    #1;
    checks++; if ({wb_cyc_o, wb_stb_o, busy, done, pass} !== 5'b0 || wb_addr_o !== 26'd0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_clear cyc_stb_b_d_p=%b addr=%h err=%0d want 0", {wb_cyc_o, wb_stb_o, busy, done, pass}, wb_addr_o, err_count); end
    @(negedge sys_clk);
    resetn = 1'b1;
    @(negedge sys_clk);
    run(2'd0, 26'h80, 16'd8, 5'd4, ok);
    checks++; if (!ok || pass !== 1'b1 || err_count !== 16'd0) begin errors++;
      $display("FAIL rstmid_rerun ok=%0d pass=%b err=%0d want 1 1 0", ok, pass, err_count); end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; cfg_mode = 2'd0; cfg_base_addr = 26'h0;
    cfg_num_words = 16'd0; cfg_burst_len = 5'd0; sdr_init_done = 1'b1;
    ack_en = 1'b1; corrupt_en = 1'b0; corrupt_addr = 26'h0;
    repeat (3) @(negedge sys_clk);
    test_reset();
    resetn = 1'b1;
    @(negedge sys_clk);
    test_increment();
    test_walk();
    test_lfsr();
    test_corrupt();
    test_timeout();
    test_zero_words();
    test_init_wait();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
